// File: rtl/word_serializer32_pkg.sv
// Shared state encodings and types for the word serializer.
// The optional parity bit is controlled by the SERIALIZER_PARITY_EN macro.
package word_serializer32_pkg;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_PAR   = 2'b10;

    typedef enum logic [1:0] {
        StIdle  = S_IDLE,
        StShift = S_SHIFT,
        StPar   = S_PAR
    } state_e;

endpackage

// File: rtl/word_serializer32_bit_counter.sv
// Bit position counter for one frame: sync clear/increment, flags the last data bit.
// Saturates at WIDTH-1 so it never wraps.
module word_serializer32_bit_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0] count_q;

    assign terminal = (count_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count_q <= '0;
        end else if (inc && !terminal) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/word_serializer32.sv
// Accepts a word over valid/ready and shifts it out one bit per clock.
// Defining SERIALIZER_PARITY_EN appends one even-parity bit to every frame.
module word_serializer32
    import word_serializer32_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_shifted;
    logic             terminal;
    logic             accept;
    logic             cnt_clear;
    logic             cnt_inc;
`ifdef SERIALIZER_PARITY_EN
    logic             parity_q;
`endif

    word_serializer32_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .terminal (terminal)
    );

    always_comb begin
        shreg_shifted = shreg_q;
        if (MSB_FIRST) begin
            shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    // Outputs decode registered state only; in_ready never sees in_valid.
    always_comb begin
        busy      = (state_q != StIdle);
        ser_valid = (state_q != StIdle);
`ifdef SERIALIZER_PARITY_EN
        ser_last  = (state_q == StPar);
        ser_out   = ((state_q == StShift) & shreg_q[OUT_IDX]) | ((state_q == StPar) & parity_q);
`else
        ser_last  = (state_q == StShift) & terminal;
        ser_out   = (state_q == StShift) & shreg_q[OUT_IDX];
`endif
        in_ready  = (state_q == StIdle) | ser_last;
    end

    assign accept    = in_valid & in_ready;
    assign cnt_clear = accept | ((state_q == StShift) & terminal);
    assign cnt_inc   = (state_q == StShift);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (accept) begin
            state_q  <= StShift;
            shreg_q  <= in_data;
`ifdef SERIALIZER_PARITY_EN
            parity_q <= ^in_data;
`endif
        end else begin
            case (state_q)
                StShift: begin
                    if (terminal) begin
`ifdef SERIALIZER_PARITY_EN
                        state_q <= StPar;
`else
                        state_q <= StIdle;
`endif
                    end else begin
                        shreg_q <= shreg_shifted;
                    end
                end
                StPar:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_word_serializer32.sv
// Directed bench: MSB-first lane (dut_a) and LSB-first lane (dut_b) checked bit by bit.
// Parity expectations follow SERIALIZER_PARITY_EN.
module tb_word_serializer32;

`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = 32 + PAR;

    typedef struct {
        bit          lane;
        logic [31:0] data;
        logic [31:0] exp_seq;  // first-sent bit at position 31
        logic        exp_par;
        bit          noise;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        sel;
    logic        va, vb;
    logic        a_ready, a_out, a_valid, a_last, a_busy;
    logic        b_ready, b_out, b_valid, b_last, b_busy;
    logic        o_ready, o_out, o_valid, o_last, o_busy;

    int checks = 0;
    int errors = 0;

    assign va = in_valid & ~sel;
    assign vb = in_valid & sel;

    assign o_ready = sel ? b_ready : a_ready;
    assign o_out   = sel ? b_out   : a_out;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_last  = sel ? b_last  : a_last;
    assign o_busy  = sel ? b_busy  : a_busy;

    word_serializer32 #(
        .WIDTH     (32),
        .MSB_FIRST (1'b1)
    ) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (va),
        .in_data   (in_data),
        .in_ready  (a_ready),
        .ser_out   (a_out),
        .ser_valid (a_valid),
        .ser_last  (a_last),
        .busy      (a_busy)
    );

    word_serializer32 #(
        .WIDTH     (32),
        .MSB_FIRST (1'b0)
    ) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (vb),
        .in_data   (in_data),
        .in_ready  (b_ready),
        .ser_out   (b_out),
        .ser_valid (b_valid),
        .ser_last  (b_last),
        .busy      (b_busy)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [31:0] seq, input logic par, input int j);
        if (j < 32) return seq[31-j];
        return par;
    endfunction

    // {valid, last, ready, busy, out} when idle
    task automatic chk_idle(input string name);
        chk(name, {o_valid, o_last, o_ready, o_busy, o_out}, 5'b00100);
    endtask

    task automatic run_frame(input logic [31:0] data, input logic [31:0] seq,
                             input logic par, input bit noise);
        chk("pre_ready", o_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = data;
        cyc();
        for (int c = 0; c < FL; c++) begin
            chk($sformatf("ser_out[%0d]", c), o_out, exp_bit(seq, par, c));
            chk($sformatf("flags[%0d]", c), {o_valid, o_last, o_ready, o_busy},
                {1'b1, c == FL - 1, c == FL - 1, 1'b1});
            in_valid = noise && (c > 0) && (c < FL - 1);
            in_data  = noise ? 32'h77665544 : data;
            cyc();
        end
        in_valid = 1'b0;
        chk_idle("post_frame");
    endtask

    task automatic back_to_back(input logic [31:0] a, input logic pa,
                                input logic [31:0] b, input logic pb);
        in_valid = 1'b1;
        in_data  = a;
        cyc();
        in_data = b;
        for (int c = 0; c < 2 * FL; c++) begin
            int j;
            j = c % FL;
            chk($sformatf("b2b_out[%0d]", c), o_out,
                (c < FL) ? exp_bit(a, pa, j) : exp_bit(b, pb, j));
            chk($sformatf("b2b_flags[%0d]", c), {o_valid, o_last, o_ready, o_busy},
                {1'b1, j == FL - 1, j == FL - 1, 1'b1});
            if (c == 2 * FL - 1) in_valid = 1'b0;
            cyc();
        end
        chk_idle("b2b_post");
    endtask

    task automatic reset_mid_frame();
        in_valid = 1'b1;
        in_data  = 32'h33221100;
        cyc();
        in_valid = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            chk($sformatf("rst_frame_out[%0d]", c), o_out, exp_bit(32'h33221100, 1'b0, c));
            if (c < 10) cyc();
        end
        reset_n = 1'b0;
        cyc();
        chk_idle("rst_mid_frame");
        reset_n = 1'b1;
        run_frame(32'h12345678, 32'h12345678, 1'b1, 1'b0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{lane: 1'b0, data: 32'h12345678, exp_seq: 32'h12345678, exp_par: 1'b1, noise: 1'b0};
        vecs[1] = '{lane: 1'b0, data: 32'h89abcdef, exp_seq: 32'h89abcdef, exp_par: 1'b0, noise: 1'b1};
        vecs[2] = '{lane: 1'b1, data: 32'h00000001, exp_seq: 32'h80000000, exp_par: 1'b1, noise: 1'b0};
        vecs[3] = '{lane: 1'b1, data: 32'h00000003, exp_seq: 32'hc0000000, exp_par: 1'b0, noise: 1'b0};
        vecs[4] = '{lane: 1'b1, data: 32'h12345678, exp_seq: 32'h1e6a2c48, exp_par: 1'b1, noise: 1'b1};

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        sel      = 1'b0;
        cyc();
        cyc();
        chk("reset_a", {a_valid, a_last, a_ready, a_busy, a_out}, 5'b00100);
        chk("reset_b", {b_valid, b_last, b_ready, b_busy, b_out}, 5'b00100);
        reset_n = 1'b1;
        cyc();
        chk("idle_a", {a_valid, a_last, a_ready, a_busy, a_out}, 5'b00100);

        for (int i = 0; i < 5; i++) begin
            sel = vecs[i].lane;
            run_frame(vecs[i].data, vecs[i].exp_seq, vecs[i].exp_par, vecs[i].noise);
        end

        sel = 1'b0;
        back_to_back(32'hffeeddcc, 1'b0, 32'hbbaa9988, 1'b0);
        reset_mid_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
